// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state encoding and round helper functions
// for the compression stage.
package sha256_pkg;

  typedef logic [31:0] word_t;
  // Index 0 is a (or H0) and sits in the most significant bits.
  typedef logic [0:7][31:0] vars_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_REQ,
    ACK_HI,
    UPDATE,
    HOLD
  } state_t;

  localparam vars_t IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input logic [4:0] n);
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 5'd2) ^ rotr(x, 5'd13) ^ rotr(x, 5'd22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 5'd6) ^ rotr(x, 5'd11) ^ rotr(x, 5'd25);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: a..h plus schedule word W and constant K
// produce the next a..h.
module sha256_round
  import sha256_pkg::*;
(
  input  vars_t cur,
  input  word_t w,
  input  word_t k,
  output vars_t nxt
);

  word_t t1;
  word_t t2;

  always_comb begin
    t1  = cur[7] + big_sigma1(cur[4]) + ch(cur[4], cur[5], cur[6]) + k + w;
    t2  = big_sigma0(cur[0]) + maj(cur[0], cur[1], cur[2]);
    nxt = {t1 + t2, cur[0], cur[1], cur[2], cur[3] + t1, cur[4], cur[5], cur[6]};
  end

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 compression stage fed word-by-word over a 4-phase wr/wa handshake.
// Define SHA_WR_SYNC_EN to put a 2-flop synchronizer on wr.
module sha256_compress
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64,
  parameter int WW     = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  output logic          wa,
  input  logic [WW-1:0] w_in,
  input  logic          init,
  output logic [255:0]  digest,
  output logic          digest_valid,
  input  logic          digest_ready,
  output state_t        fsm_state
);

  localparam int CNT_W = $clog2(ROUNDS + 1);

  // Handshake: a word is taken when effective wr=1 and wa=0; wa then stays
  // high until effective wr falls. The digest moves on digest_valid & ready.
  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  round_cnt;
  vars_t             h_reg;
  vars_t             work;
  vars_t             round_src;
  vars_t             round_out;
  logic              wr_eff;
  logic              accept;
  logic              wr_fall;
  logic              digest_take;

`ifdef SHA_WR_SYNC_EN
  logic [1:0] wr_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_sync <= 2'b00;
    else        wr_sync <= {wr_sync[0], wr};
  end

  assign wr_eff = wr_sync[1];
`else
  assign wr_eff = wr;
`endif

  // The first round of a block starts from the chaining value.
  assign round_src = (state == IDLE) ? h_reg : work;

  sha256_round u_round (
    .cur (round_src),
    .w   (w_in),
    .k   (K[round_cnt[5:0]]),
    .nxt (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    wr_fall     = 1'b0;
    digest_take = 1'b0;
    case (state)
      IDLE, WAIT_REQ: begin
        if (wr_eff && !wa) begin
          accept     = 1'b1;
          state_next = ACK_HI;
        end
      end
      ACK_HI: begin
        if (!wr_eff) begin
          wr_fall    = 1'b1;
          state_next = (round_cnt == CNT_W'(ROUNDS)) ? UPDATE : WAIT_REQ;
        end
      end
      UPDATE: state_next = HOLD;
      HOLD: begin
        if ((digest_valid && digest_ready) || init) begin
          digest_take = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wa           <= 1'b0;
      digest_valid <= 1'b0;
      h_reg        <= IV;
      work         <= '0;
      round_cnt    <= '0;
    end else begin
      if (accept) begin
        work      <= round_out;
        round_cnt <= round_cnt + 1'b1;
        wa        <= 1'b1;
      end
      if (wr_fall) wa <= 1'b0;
      if (state == UPDATE) begin
        for (int i = 0; i < 8; i++) h_reg[i] <= h_reg[i] + work[i];
        round_cnt    <= '0;
        digest_valid <= 1'b1;
      end
      if (digest_take) digest_valid <= 1'b0;
      if (init && (state == IDLE || state == HOLD)) h_reg <= IV;
    end
  end

  assign digest    = h_reg;
  assign fsm_state = state;

endmodule

// File: tb/tb_sha256_compress.sv
// Directed bench for sha256_compress: a ring-like word driver, a digest
// scoreboard queue and a wr/wa protocol monitor.
module tb_sha256_compress;
  import sha256_pkg::*;

  localparam logic [255:0] IV_C   = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_D  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_H1 = 256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
  localparam logic [255:0] TWO_D  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
`ifdef SHA_WR_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr = 1'b0;
  logic         init = 1'b0;
  logic         digest_ready = 1'b1;
  logic [31:0]  w_in = 32'h0;
  logic         wa;
  logic [255:0] digest;
  logic         digest_valid;
  state_t       fsm_state;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [255:0] exp_q[$];
  logic [31:0]  msg[16];
  logic [31:0]  sched[64];
  logic         wr_edge = 1'b0;
  logic         wa_last = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

  sha256_compress dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr           (wr),
    .wa           (wa),
    .w_in         (w_in),
    .init         (init),
    .digest       (digest),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready),
    .fsm_state    (fsm_state)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // message schedule as the ring would produce it
  task automatic expand();
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) sched[t] = msg[t];
    for (int t = 16; t < 64; t++) begin
      s0 = ror32(sched[t-15], 7) ^ ror32(sched[t-15], 18) ^ (sched[t-15] >> 3);
      s1 = ror32(sched[t-2], 17) ^ ror32(sched[t-2], 19) ^ (sched[t-2] >> 10);
      sched[t] = s1 + sched[t-7] + s0 + sched[t-16];
    end
  endtask

  task automatic load_abc();
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
    expand();
  endtask

  task automatic load_two1();
    msg = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
            32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
            32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    expand();
  endtask

  task automatic load_two2();
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[15] = 32'h000001c0;
    expand();
  endtask

  task automatic pulse_init();
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  // driver: one 4-phase handshake, called and returning on a negedge
  task automatic send_word(input logic [31:0] w, input int rise_lat);
    int cnt;
    w_in = w;
    wr   = 1'b1;
    cnt  = 0;
    do begin @(negedge clk); cnt++; end while (wa !== 1'b1 && cnt < 40);
    check("wa_rise_latency", 256'(cnt), 256'(rise_lat));
    wr  = 1'b0;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (wa !== 1'b0 && cnt < 40);
    check("wa_fall_latency", 256'(cnt), 256'(LAT));
  endtask

  task automatic drive_block(input int n_words, input int init_at, input bit pre_raised,
                             input logic [255:0] exp);
    for (int i = 0; i < n_words; i++) begin
      send_word(sched[i], (pre_raised && i == 0) ? 2 : LAT);
      if (i == init_at) pulse_init();
    end
    if (n_words == 64) begin
      check("valid_at_last_wa_fall", 256'(digest_valid), 256'(1'b0));
      exp_q.push_back(exp);
      @(negedge clk);
      check("valid_one_edge_later", 256'(digest_valid), 256'(1'b1));
    end
  endtask

  // scoreboard: compare each digest as it is handed over
  always @(negedge clk) begin
    #1;
    if (rst_n === 1'b1 && digest_valid === 1'b1 && digest_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $error("FAIL digest_unexpected: observed %0h expected none", digest);
      end else begin
        check("digest", digest, exp_q.pop_front());
      end
    end
  end

  // protocol monitor: wa may only move toward the wr level seen at that edge
  always @(posedge clk) wr_edge = wr;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && wa !== wa_last) check("wa_follows_wr", 256'(wa), 256'(wr_edge));
    wa_last = wa;
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_wa", 256'(wa), 256'(1'b0));
    check("reset_valid", 256'(digest_valid), 256'(1'b0));
    check("reset_digest", digest, IV_C);
    check("reset_state", 256'(fsm_state), 256'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // single-block "abc"
    load_abc();
    pulse_init();
    drive_block(64, -1, 1'b0, ABC_D);
    repeat (3) @(negedge clk);

    // two-block message with the digest held back after block 1
    load_two1();
    pulse_init();
    digest_ready = 1'b0;
    drive_block(64, -1, 1'b0, TWO_H1);
    load_two2();
    w_in = sched[0];
    wr   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("bp_wa_low", 256'(wa), 256'(1'b0));
      check("bp_digest_held", digest, TWO_H1);
      check("bp_valid_held", 256'(digest_valid), 256'(1'b1));
    end
    digest_ready = 1'b1;
    drive_block(64, -1, 1'b1, TWO_D);
    repeat (3) @(negedge clk);

    // reset after 10 words of a block
    load_abc();
    pulse_init();
    drive_block(10, -1, 1'b0, 256'h0);
    rst_n = 1'b0;
    #1;
    check("midreset_wa", 256'(wa), 256'(1'b0));
    check("midreset_digest", digest, IV_C);
    check("midreset_valid", 256'(digest_valid), 256'(1'b0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_block(64, -1, 1'b0, ABC_D);
    repeat (3) @(negedge clk);

    // init pulse mid-block must be ignored
    pulse_init();
    drive_block(64, 30, 1'b0, ABC_D);
    repeat (5) @(negedge clk);

    check("queue_drained", 256'(exp_q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/sha256_compress.md
# sha256_compress

Clocked SHA-256 compression stage that sits directly downstream of the asynchronous message-schedule `ring`. It consumes the ring's stream of 32-bit schedule words W[0..63] over the ring's 4-phase right-side handshake (`rr`/`ra`/`dout`). It runs one round per accepted word and accumulates the chaining value H0..H7 across blocks. After each 64-word block it presents a 256-bit digest on a valid/ready port.

## Interface
- `ROUNDS`, 64, words consumed per block; rounds per compression.
- `WW`, 32, schedule word width; must match the ring's `dout` width.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr`  in  1  word request; connects to ring `rr`. It is asynchronous to `clk` when `SHA_WR_SYNC_EN` is defined.
- `wa`  out  1  word acknowledge; connects to ring `ra`.
- `w_in`  in  WW  schedule word; connects to ring `dout`. Stable while `wr`=1.
- `init`  in  1  one-cycle pulse: reload H0..H7 with the IV (start of a new message).
- `digest`  out  256  H0..H7, with H0 in [255:224].
- `digest_valid`  out  1  digest holds the result of a completed block.
- `digest_ready`  in  1  consumer accepts the digest.

## Operation
- FSM states:
  - IDLE: round_cnt=0, waiting for the first word of a block.
  - WAIT_REQ: waiting for the next word.
  - ACK_HI: `wa`=1, waiting for `wr` to fall.
  - UPDATE: perform H += a..h.
  - HOLD: `digest_valid`=1.
- Word accept in IDLE or WAIT_REQ requires effective `wr`=1 and `wa`=0.
  - On accept, the round uses W=`w_in` and K[round_cnt].
  - In IDLE, the round's a..h source is H0..H7, not the working registers.
  - round_cnt increments, `wa`→1, state→ACK_HI.
- ACK_HI:
  - On effective `wr`=0, `wa`→0.
  - If round_cnt==ROUNDS, go to UPDATE; otherwise go to WAIT_REQ.
- UPDATE: Hi ← Hi + working var (mod 2^32, for i=0..7), round_cnt←0, `digest_valid`→1, state→HOLD.
- HOLD:
  - When `digest_valid`=1 and `digest_ready`=1 at the same edge, `digest_valid`→0 and state→IDLE.
  - No word is accepted in HOLD; `wa` stays 0, which backpressures the ring.
- Round arithmetic, all mod 2^32:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K + W
  - T2 = Σ0(a) + Maj(a,b,c)
  - Register update: a←T1+T2, e←d+T1, and the remaining variables shift.
- `init`:
  - Honoured only in IDLE or HOLD; H←IV.
  - In HOLD it also clears `digest_valid`.
  - Ignored mid-block (WAIT_REQ/ACK_HI/UPDATE).
- Reset (asserted at any time, including mid-block):
  - `wa`=0, `digest_valid`=0, H=IV, a..h=0, round_cnt=0, state=IDLE, synchronizer flops=0.
  - The ring must be reset alongside this block.

## Timing
- "Effective `wr`" is `wr` after the optional synchronizer.
- Without `SHA_WR_SYNC_EN`:
  - `wr` sampled high at edge N → round applied and `wa`=1 after edge N.
  - `wr` sampled low at edge M → `wa`=0 after edge M.
- With `SHA_WR_SYNC_EN`, both the rise and fall responses occur 2 edges later.
- `digest_valid` rises 1 edge after the `wa` fall that follows the 64th word.
- Block throughput: 64 four-phase handshakes plus 1 UPDATE cycle. The digest remains held in HOLD until it is accepted.
- `w_in` is sampled only on the accept edge.

## Configuration
- `SHA_WR_SYNC_EN` defined: a 2-flop synchronizer on `wr` is instantiated (the ring's asynchronous `rr` domain). This is the safe default for silicon.
- Not defined: `wr` is used directly. This is only legal when the upstream source is synchronous to `clk`; it saves 2 cycles per handshake edge.

## Structure
- `sha256_pkg` holds:
  - the 64-entry K constant array;
  - the IV constant (6a09e667 … 5be0cd19);
  - the state enum;
  - functions Σ0, Σ1, Ch, Maj.
- Sub-module `sha256_round`: purely combinational.
  - Inputs: a..h, W, K.
  - Outputs: next a..h.
- The top level holds the FSM, counter, synchronizer and H registers.

## Test plan
- Reset, `init`, then 64 schedule words of "abc" via the ring golden file (W0=61626380):
  - `digest`=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  - `digest_valid`=1 one edge after the final `wa` fall.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", no `init` between blocks:
  - final digest=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- Backpressure: hold `digest_ready`=0 after block 1 and raise `wr` for block 2:
  - `wa` stays 0 and `digest` is unchanged;
  - after `digest_ready`=1 for one cycle, `wa` rises and block 2 proceeds.
- Reset mid-block: drop `rst_n` after 10 words.
  - Immediately: `wa`=0, `digest`=IV, `digest_valid`=0.
  - A full "abc" block afterwards gives the correct digest.
- `init` pulse after word 30 of a block: ignored; the "abc" digest is still correct.
- Handshake protocol check (both macro settings):
  - `wa` never rises while `wr`=0;
  - `wa` never falls while `wr`=1;
  - rise latency is 1 edge (no sync) or 3 edges (sync).
